// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges MEM-stage results with a 2-entry long-latency result FIFO.
// Define RV32_WB_STARVE_GUARD_EN to enable the starvation guard (forced FIFO drain via pipe_stall).
module wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic [31:0] mem_data,
    input  logic        ll_valid,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_data,
    output logic        ll_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    output logic        ll_hazard,
    output logic        pipe_stall,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic [31:0] wb_data
);
    localparam int unsigned RegW  = 5;
    localparam int unsigned DataW = 32;

    typedef logic [RegW-1:0]  reg_addr_t;
    typedef logic [DataW-1:0] word_t;

    typedef struct packed {
        reg_addr_t rd;
        word_t     data;
    } ll_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    if ((STARVE_LIMIT == 0) || (STARVE_LIMIT > 15)) begin : g_bad_limit
        $error("wb_arbiter: STARVE_LIMIT must be in 1..15");
    end

    fifo_state_e state_q, state_d;
    ll_entry_t   head_q, head_d, tail_q, tail_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    reg_addr_t   wb_rd_q, wb_rd_d;
    word_t       wb_data_q, wb_data_d;

    logic        fifo_nonempty, hs_keep, mem_wr, force_head, deq, enq;
    ll_entry_t   hs_entry;
    reg_addr_t [2:0] id_addr;
    logic [2:0]  id_hit;

    // Results with rd=0 are accepted but never stored or written back.
    assign fifo_nonempty = (state_q != EMPTY);
    assign ll_ready      = rst_n && (state_q != FULL);
    assign hs_keep       = ll_valid && ll_ready && (ll_rd != '0);
    assign hs_entry      = '{rd: ll_rd, data: ll_data};
    assign mem_wr        = !force_head && mem_regwrite && (mem_rd != '0);
    assign deq           = fifo_nonempty && (force_head || !mem_wr);
    assign enq           = hs_keep && (fifo_nonempty || mem_wr);

`ifdef RV32_WB_STARVE_GUARD_EN
    localparam int unsigned CntW = 4;

    logic [CntW-1:0] starve_q, starve_d;

    // Counts cycles the FIFO head waits behind MEM traffic.
    always_comb begin
        starve_d = starve_q;
        if (deq) begin
            starve_d = '0;
        end else if (fifo_nonempty) begin
            starve_d = starve_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign force_head = rst_n && fifo_nonempty && (starve_q == CntW'(STARVE_LIMIT));
`else
    assign force_head = 1'b0;
`endif

    assign pipe_stall = force_head;

    // Hazard covers queued entries and a result accepted this cycle.
    assign id_addr = {id_rd, id_rs2, id_rs1};

    always_comb begin
        id_hit = '0;
        for (int i = 0; i < 3; i++) begin
            id_hit[i] = (id_addr[i] != '0) &&
                        ((fifo_nonempty && (head_q.rd == id_addr[i])) ||
                         ((state_q == FULL) && (tail_q.rd == id_addr[i])) ||
                         (hs_keep && (ll_rd == id_addr[i])));
        end
    end

    assign ll_hazard = rst_n && (|id_hit);

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        wb_regwrite_d = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;

        if (deq) begin
            wb_regwrite_d = 1'b1;
            wb_rd_d       = head_q.rd;
            wb_data_d     = head_q.data;
        end else if (mem_wr) begin
            wb_regwrite_d = 1'b1;
            wb_rd_d       = mem_rd;
            wb_data_d     = mem_data;
        end else if (hs_keep) begin
            wb_regwrite_d = 1'b1;
            wb_rd_d       = ll_rd;
            wb_data_d     = ll_data;
        end

        case (state_q)
            EMPTY: begin
                if (enq) begin
                    head_d  = hs_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (deq && enq) begin
                    head_d = hs_entry;
                end else if (deq) begin
                    state_d = EMPTY;
                end else if (enq) begin
                    tail_d  = hs_entry;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (deq) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            head_q        <= '0;
            tail_q        <= '0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
        end
    end

    assign wb_regwrite = wb_regwrite_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;

endmodule
